dm_copy_engine: RTL and testbench
=================================

// Module: dm_copy_engine
// PURPOSE
//   Initiator for the single-port data memory (port set a/rd/wd/we): copies a block of
//   32-bit words from a source byte address to a destination byte address, word by word.
//   Sits beside the datapath as a small memory-to-memory mover that owns the memory port while busy.
//   A mux outside this block selects between this engine and the CPU.
//   The memory has a combinational read and a level-sensitive write, so every
//   memory-side output of this block is driven straight from a flop.
// PARAMETERS
//   LEN_W   11   width of word count; max transfer 2**LEN_W-1 words (default 2047)
// PORTS
//   clk        in   1       single clock, all state changes on posedge
//   reset      in   1       asynchronous, active-high reset
//   start      in   1       request copy; sampled only in IDLE
//   abort      in   1       cancel transfer in progress
//   src        in   32      source byte address (bits[1:0] ignored, forced 0)
//   dst        in   32      destination byte address (bits[1:0] ignored, forced 0)
//   len        in   LEN_W   number of words to copy
//   busy       out  1       high from accepted start until return to IDLE
//   done       out  1       one-cycle pulse: transfer completed normally
//   aborted    out  1       one-cycle pulse: transfer ended by abort
//   dm_a       out  32      memory byte address (registered)
//   dm_wd      out  32      memory write data (registered)
//   dm_we      out  1       memory write enable (registered, glitch-free)
//   dm_rd      in   32      memory read data (combinational from dm_a)
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE.
//     All outputs 0: busy, done, aborted, dm_a, dm_wd, dm_we.
//     Internal pointers and count cleared.
//     dm_we drops at once; a word whose write is interrupted is undefined.
//   States: IDLE, READ, WRITE, FIN.
//   IDLE:
//     start=1 and len!=0 -> READ.
//       Latch sp=src&~3, dp=dst&~3, cnt=len.
//       dm_a<=sp, busy<=1.
//     start=1 and len==0 -> FIN, busy<=1. No memory access.
//     Otherwise stay in IDLE. dm_we held 0.
//   READ (1 cycle):
//     dm_a holds sp.
//     At the edge: dm_wd<=dm_rd, dm_a<=dp, dm_we<=1, go to WRITE.
//   WRITE (1 cycle):
//     dm_we=1 with dm_a and dm_wd stable for the whole cycle.
//     At the edge: dm_we<=0, sp+=4, dp+=4, cnt-=1.
//     If the new cnt!=0 -> READ with dm_a<=new sp; else -> FIN.
//   FIN (1 cycle):
//     done=1 (or aborted=1 if entered via abort).
//     At the edge: busy<=0, return to IDLE.
//   Throughput: 2 cycles/word.
//     Start accepted at edge E0 -> done high in cycle 2*len+1 after E0.
//   Pointer arithmetic: 32-bit modulo 2**32; 0xFFFFFFFC+4 wraps to 0x00000000.
//   Overlap: strictly ascending order, each word read then written before the next read.
//     If dst>src and the regions overlap, the source data is overwritten as the copy proceeds.
//     That result is the defined behaviour.
//   abort=1 in READ or WRITE:
//     next edge -> FIN with aborted flag, dm_we<=0.
//     A write already in its WRITE cycle completes (dm_we was high that cycle).
//     done is not pulsed.
//   abort in IDLE or FIN: ignored.
//   start while busy: ignored, not queued.
//   abort and start together in IDLE: start wins.
//   src/dst/len may change after acceptance without effect.
// TESTING
//   1 Preload mem[0..3]=A0..A3; src=0x0, dst=0x100, len=4
//     -> mem[0x40..0x43]=A0..A3; done in cycle 9 after E0; exactly 4 we pulses.
//   2 len=0, start
//     -> done in cycle 1, busy for 1 cycle, dm_we never high, memory unchanged.
//   3 src=0x3, dst=0x102, len=1
//     -> low bits masked; word at byte 0x0 copied to byte 0x100.
//   4 src=0x10, dst=0x14, len=3, mem[4..6]=X,Y,Z
//     -> mem[5..7]=X,X,X (forward overlap as defined).
//   5 Abort during the 2nd WRITE of len=5
//     -> 2 words written, aborted pulse, no done, idle next; a new start then works normally.
//   6 Reset asserted mid-WRITE
//     -> dm_we=0 and busy=0 immediately; start after release copies correctly.
//   Plus: start pulsed while busy has no effect; the copy ending at address 0xFFFFFFFC wraps dp to 0.

Source files
------------

// File: rtl/dm_copy_engine.sv
// Word-by-word memory-to-memory copy engine driving the single-port data memory.
// Every memory-side output comes straight from a flop; done/aborted decode the FIN state.
module dm_copy_engine #(
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [31:0]      dm_a,
    output logic [31:0]      dm_wd,
    output logic             dm_we,
    input  logic [31:0]      dm_rd
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        FIN
    } state_t;

    state_t           state, state_n;
    logic [31:0]      sp, sp_n, dp, dp_n;
    logic [31:0]      a_n, wd_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic             we_n, busy_n, abf, abf_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sp    <= '0;
            dp    <= '0;
            cnt   <= '0;
            dm_a  <= '0;
            dm_wd <= '0;
            dm_we <= 1'b0;
            busy  <= 1'b0;
            abf   <= 1'b0;
        end else begin
            state <= state_n;
            sp    <= sp_n;
            dp    <= dp_n;
            cnt   <= cnt_n;
            dm_a  <= a_n;
            dm_wd <= wd_n;
            dm_we <= we_n;
            busy  <= busy_n;
            abf   <= abf_n;
        end
    end

    always_comb begin
        state_n = state;
        sp_n    = sp;
        dp_n    = dp;
        cnt_n   = cnt;
        a_n     = dm_a;
        wd_n    = dm_wd;
        we_n    = 1'b0;
        busy_n  = busy;
        abf_n   = abf;
        case (state)
            IDLE: begin
                abf_n = 1'b0;
                if (start) begin
                    busy_n = 1'b1;
                    if (len != '0) begin
                        sp_n    = {src[31:2], 2'b00};
                        dp_n    = {dst[31:2], 2'b00};
                        cnt_n   = len;
                        a_n     = {src[31:2], 2'b00};
                        state_n = READ;
                    end else begin
                        state_n = FIN;
                    end
                end
            end
            READ: begin
                if (abort) begin
                    abf_n   = 1'b1;
                    state_n = FIN;
                end else begin
                    wd_n    = dm_rd;
                    a_n     = dp;
                    we_n    = 1'b1;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    abf_n   = 1'b1;
                    state_n = FIN;
                end else begin
                    sp_n  = sp + 32'd4;
                    dp_n  = dp + 32'd4;
                    cnt_n = cnt - 1'b1;
                    // cnt==1 here means the word just written was the last one
                    if (cnt != LEN_W'(1)) begin
                        a_n     = sp + 32'd4;
                        state_n = READ;
                    end else begin
                        state_n = FIN;
                    end
                end
            end
            FIN: begin
                busy_n  = 1'b0;
                abf_n   = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign done    = (state == FIN) && !abf;
    assign aborted = (state == FIN) && abf;

endmodule

// File: tb/tb_dm_copy_engine.sv
// Bench for dm_copy_engine: behavioural memory, write log and a reference copy model.
module tb_dm_copy_engine;

    localparam int LEN_W = 11;

    logic             clk = 1'b0;
    logic             reset, start, abort;
    logic [31:0]      src, dst;
    logic [LEN_W-1:0] len;
    logic             busy, done, aborted, dm_we;
    logic [31:0]      dm_a, dm_wd, dm_rd;

    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        init_we = 1'b0;
    logic [9:0]  init_idx = '0;
    logic [31:0] init_d = '0;

    logic [31:0] wlog_a[$], wlog_d[$];
    logic [31:0] exp_a[$], exp_d[$];
    int          wptr = 0;
    int          vectors = 0;
    int          errors = 0;

    dm_copy_engine #(.LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .aborted(aborted),
        .dm_a(dm_a), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
    );

    always #5 clk = ~clk;

    assign dm_rd = mem[dm_a[11:2]];

    always @(posedge clk) begin
        if (init_we) begin
            mem[init_idx] <= init_d;
        end else if (dm_we) begin
            mem[dm_a[11:2]] <= dm_wd;
            wlog_a.push_back(dm_a);
            wlog_d.push_back(dm_wd);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: ascending word copy against the current memory image, wrapping modulo 2**32.
    task automatic model(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] sa, da;
        sa = s & ~32'h3;
        da = d & ~32'h3;
        for (int i = 0; i < n; i++) begin
            ref_mem[da[11:2]] = ref_mem[sa[11:2]];
            exp_a.push_back(da);
            exp_d.push_back(ref_mem[da[11:2]]);
            sa = sa + 32'd4;
            da = da + 32'd4;
        end
    endtask

    task automatic check_writes(input string tag);
        int nw, ne, diff;
        nw = wlog_a.size() - wptr;
        ne = exp_a.size();
        chk({tag, "_nwrites"}, 32'(nw), 32'(ne));
        for (int j = 0; j < nw && j < ne; j++) begin
            chk({tag, "_waddr"}, wlog_a[wptr+j], exp_a[j]);
            chk({tag, "_wdata"}, wlog_d[wptr+j], exp_d[j]);
        end
        wptr = wlog_a.size();
        exp_a.delete();
        exp_d.delete();
        diff = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== ref_mem[i]) diff++;
        chk({tag, "_memdiff"}, 32'(diff), 32'd0);
    endtask

    // abort_at<0: abort raised together with start; restart_at: cycle with a stray start.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] n,
                       input int abort_at, input int restart_at,
                       output int fin_cyc, output logic got_done, output logic got_abort);
        @(negedge clk);
        src = s; dst = d; len = n; start = 1'b1; abort = (abort_at < 0);
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        src = $urandom; dst = $urandom; len = LEN_W'($urandom);
        fin_cyc = 0; got_done = 1'b0; got_abort = 1'b0;
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk);
            if (k == 1) chk("busy_cycle1", 32'(busy), 32'd1);
            abort = (k == abort_at);
            start = (k == restart_at);
            if (done || aborted) begin
                fin_cyc = k; got_done = done; got_abort = aborted;
                break;
            end
        end
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("busy_after_fin", 32'(busy), 32'd0);
        chk("pulse_after_fin", 32'({done, aborted}), 32'd0);
    endtask

    initial begin
        int          fc;
        logic        gd, ga;
        logic [31:0] rs, rd;
        int          rn;

        reset = 1'b1; start = 1'b0; abort = 1'b0; src = '0; dst = '0; len = '0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            init_we  = 1'b1;
            init_idx = 10'(i);
            init_d   = (i < 4) ? (32'hA0 + 32'(i)) : $urandom;
            ref_mem[i] = init_d;
        end
        @(negedge clk);
        init_we = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_dm_a", dm_a, 32'd0);
        chk("rst_dm_wd", dm_wd, 32'd0);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        reset = 1'b0;

        // basic 4-word copy
        run(32'h0, 32'h100, 11'd4, 0, 0, fc, gd, ga);
        model(32'h0, 32'h100, 4);
        chk("t1_fin_cycle", 32'(fc), 32'd9);
        chk("t1_done", 32'(gd), 32'd1);
        chk("t1_aborted", 32'(ga), 32'd0);
        check_writes("t1");

        // zero length
        run(32'h40, 32'h300, 11'd0, 0, 0, fc, gd, ga);
        chk("t2_fin_cycle", 32'(fc), 32'd1);
        chk("t2_done", 32'(gd), 32'd1);
        check_writes("t2");

        // unaligned addresses masked
        run(32'h3, 32'h102, 11'd1, 0, 0, fc, gd, ga);
        model(32'h3, 32'h102, 1);
        chk("t3_fin_cycle", 32'(fc), 32'd3);
        check_writes("t3");

        // forward overlap
        run(32'h10, 32'h14, 11'd3, 0, 0, fc, gd, ga);
        model(32'h10, 32'h14, 3);
        chk("t4_fin_cycle", 32'(fc), 32'd7);
        chk("t4_word7", ref_mem[7], ref_mem[5]);
        check_writes("t4");

        // abort during the second WRITE
        run(32'h20, 32'h380, 11'd5, 4, 0, fc, gd, ga);
        model(32'h20, 32'h380, 2);
        chk("t5_fin_cycle", 32'(fc), 32'd5);
        chk("t5_aborted", 32'(ga), 32'd1);
        chk("t5_no_done", 32'(gd), 32'd0);
        check_writes("t5");
        run(32'h30, 32'h3C0, 11'd3, 0, 0, fc, gd, ga);
        model(32'h30, 32'h3C0, 3);
        chk("t5b_fin_cycle", 32'(fc), 32'd7);
        chk("t5b_done", 32'(gd), 32'd1);
        check_writes("t5b");

        // reset in the middle of a WRITE cycle
        @(negedge clk);
        src = 32'h80; dst = 32'h500; len = 11'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_we_before", 32'(dm_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_we_reset", 32'(dm_we), 32'd0);
        chk("t6_busy_reset", 32'(busy), 32'd0);
        chk("t6_dm_a_reset", dm_a, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check_writes("t6_reset");
        run(32'h80, 32'h500, 11'd3, 0, 0, fc, gd, ga);
        model(32'h80, 32'h500, 3);
        chk("t6_fin_cycle", 32'(fc), 32'd7);
        check_writes("t6");

        // start pulsed while busy is ignored
        run(32'h140, 32'h600, 11'd4, 0, 3, fc, gd, ga);
        model(32'h140, 32'h600, 4);
        chk("busy_start_fin", 32'(fc), 32'd9);
        chk("busy_start_done", 32'(gd), 32'd1);
        check_writes("busy_start");

        // start and abort together in IDLE: start wins
        run(32'h180, 32'h640, 11'd2, -1, 0, fc, gd, ga);
        model(32'h180, 32'h640, 2);
        chk("start_abort_fin", 32'(fc), 32'd5);
        chk("start_abort_done", 32'(gd), 32'd1);
        check_writes("start_abort");

        // destination wraps past 0xFFFFFFFC
        run(32'h200, 32'hFFFFFFF8, 11'd3, 0, 0, fc, gd, ga);
        model(32'h200, 32'hFFFFFFF8, 3);
        chk("wrap_fin", 32'(fc), 32'd7);
        check_writes("wrap");

        // randomized copies
        for (int r = 0; r < 8; r++) begin
            rs = 32'($urandom_range(0, 4095));
            rd = 32'($urandom_range(0, 4095));
            rn = $urandom_range(1, 16);
            run(rs, rd, LEN_W'(rn), 0, 0, fc, gd, ga);
            model(rs, rd, rn);
            chk("rnd_fin", 32'(fc), 32'(2 * rn + 1));
            chk("rnd_done", 32'(gd), 32'd1);
            check_writes("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
